tilexy_cl_rx: RTL
=================

// Module: tileXY_cl_rx
// PURPOSE
//  Receive end of the tile X/Y cache-line ring link. Accepts wrreq-format flits (732 b incl. extra) from
//  both link directions, ejects flits addressed to this tile into per-direction FIFOs, and forwards all
//  other flits one hop through a registered stage. Drives the per-direction almost-full (extra) bit
//  back to the upstream sender, and presents ejected lines to the tile cache on one valid/ready port.
// PARAMETERS
//  TILE_X   0  tile X coordinate, compared against TX[4:0]
//  TILE_Y   0  tile Y coordinate, compared against TY[4:0]
//  DEPTH    8  eject FIFO entries per direction; power of 2, >=4
//  AF_LVL   6  occupancy at or above which link_full_out[d] asserts
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous reset, active-high
//  link_in        in   2x732    flits from dir 0/1 [731]=extra (ignored), [729]=snd valid
//  link_full_out  out  2        to upstream sender: stop issuing (drives its extra input)
//  fwd_out        out  2x731    forwarded flit to next hop; [729]=snd valid
//  fwd_full_in    in   2        next hop almost-full for dir 0/1
//  out_valid      out  1        ejected line available
//  out_ready      in   1        cache accepts line
//  out_data       out  528      wrreq data[527:0]
//  out_addr       out  4x37     wrreq addr[728:581]
//  out_size       out  42       {shared,~shared,sz[39:0]}
//  out_expun      out  1        wrreq expun[730]
//  out_dir        out  1        source direction of the presented line
//  ovf_err        out  2        sticky: flit lost for dir d (FIFO full or fwd stage blocked)
// BEHAVIOUR
//  Field map: data 527:0, XDONE 528, YDONE 529, TX 534:530, TY 539:535, sz 579:540,
//   shared 580, addr 728:581, snd 729, expun 730.
//  Reset: all FIFOs empty, rd/wr pointers 0, fwd stages empty (fwd_out snd=0, other bits 0),
//   out_valid=0, link_full_out=0, ovf_err=0, RR pointer = dir 0.
//  Classify per direction, each cycle, only when snd=1:
//   TX==TILE_X && TY==TILE_Y -> eject (write FIFO[d]); otherwise -> forward stage[d].
//  Eject write: lands in FIFO[d] at the clock edge; the line is visible on out_* one cycle later.
//   FIFO full at arrival -> flit dropped, ovf_err[d] set, pointers unchanged.
//  Forward stage: 1-entry register per direction; 1-cycle latency in->fwd_out.
//   Stage empty, or fwd_full_in[d]=0 -> stage loads the arriving flit (or empties if none).
//   fwd_full_in[d]=1 and stage full -> stage holds; a new forward flit is dropped, ovf_err[d] set.
//  link_full_out[d] is registered: 1 when count[d] >= AF_LVL, or when the stage is full and
//   fwd_full_in[d]=1. The sender stops within 2 cycles; DEPTH-AF_LVL=2 entries absorb in-flight flits.
//  Output arbitration: out_valid = |nonempty. If both directions are nonempty, grant the RR-pointer dir.
//   If one is nonempty, grant it. out_* is a combinational mux of the granted FIFO head.
//   Pop on out_valid&&out_ready. The RR pointer flips to the other dir after each pop taken while both
//   were nonempty. The grant holds (out_dir stable) while out_valid&&!out_ready.
//  Simultaneous push+pop on the same FIFO: count unchanged, both legal even when full
//   (the pop frees the slot in the same edge).
//  Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
//  rst mid-transfer discards all buffered and staged flits. ovf_err clears only on rst.
// STRUCTURE
//  Shared package tilexy_pkg: wrreq field ranges (data/XDONE/YDONE/TX/TY/sz/shared/addr/snd/expun/
//   extra), WRREQ_W=731, LINK_W=732. The existing wrreq ranges in the tx block move there too.
//  One sub-module: tileXY_eject_fifo (DEPTH x 731, push/pop/count/full/empty), instanced twice.
//  Arbiter, forward stages and almost-full logic live in the top.
// TESTING
//  1 Single eject: dir0 flit TX=TILE_X,TY=TILE_Y, data=528'hA5.., out_ready=1 -> out_valid on cycle 2,
//    out_data=A5.., out_dir=0, FIFO empty after pop.
//  2 Forward: dir1 flit TX=TILE_X+1 -> fwd_out[1] equals input next cycle, out_valid stays 0.
//  3 Fill/backpressure: out_ready=0, 8 eject flits on dir0 -> link_full_out[0]=1 the cycle after
//    count=6; 9th flit dropped, ovf_err[0]=1, 8 lines drained in order after out_ready=1.
//  4 RR fairness: both FIFOs hold 3 lines, out_ready=1 -> out_dir sequence 0,1,0,1,0,1.
//  5 Forward stall: fwd_full_in[0]=1 with stage full, new fwd flit -> stage unchanged, ovf_err[0]=1,
//    link_full_out[0]=1.
//  6 Reset mid-op: rst with 4 lines queued, out_ready=0 -> next cycle out_valid=0,
//    link_full_out=0, ovf_err=0, fwd_out snd=0.

Source files
------------

// File: rtl/tilexy_pkg.sv
// Shared wrreq flit layout for the tile X/Y cache-line ring link (tx and rx blocks).
package tilexy_pkg;
  localparam int WRREQ_W  = 731;
  localparam int LINK_W   = 732;

  localparam int DATA_LSB = 0;
  localparam int DATA_MSB = 527;
  localparam int XDONE    = 528;
  localparam int YDONE    = 529;
  localparam int TX_LSB   = 530;
  localparam int TX_MSB   = 534;
  localparam int TY_LSB   = 535;
  localparam int TY_MSB   = 539;
  localparam int SZ_LSB   = 540;
  localparam int SZ_MSB   = 579;
  localparam int SHARED   = 580;
  localparam int ADDR_LSB = 581;
  localparam int ADDR_MSB = 728;
  localparam int SND      = 729;
  localparam int EXPUN    = 730;
  localparam int EXTRA    = 731;

  typedef logic [WRREQ_W-1:0] wrreq_t;
  typedef logic [LINK_W-1:0]  link_t;

  // Cache-side size word: shared flag in both polarities ahead of the byte size.
  function automatic logic [41:0] cl_size(input wrreq_t f);
    return {f[SHARED], ~f[SHARED], f[SZ_MSB:SZ_LSB]};
  endfunction
endpackage

// File: rtl/tilexy_cl_rx_if.sv
// Link, forward and cache-side signals of the cache-line ring receiver.
interface tilexy_cl_rx_if import tilexy_pkg::*; ();
  logic [1:0][LINK_W-1:0]  link_in;
  logic [1:0]              link_full_out;
  logic [1:0][WRREQ_W-1:0] fwd_out;
  logic [1:0]              fwd_full_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [527:0]            out_data;
  logic [3:0][36:0]        out_addr;
  logic [41:0]             out_size;
  logic                    out_expun;
  logic                    out_dir;
  logic [1:0]              ovf_err;

  modport slave (
    input  link_in, fwd_full_in, out_ready,
    output link_full_out, fwd_out, out_valid, out_data, out_addr, out_size,
           out_expun, out_dir, ovf_err
  );
  modport master (
    output link_in, fwd_full_in, out_ready,
    input  link_full_out, fwd_out, out_valid, out_data, out_addr, out_size,
           out_expun, out_dir, ovf_err
  );
endinterface

// File: rtl/tilexy_cl_rx_eject_fifo.sv
// Per-direction eject FIFO; a push into a full FIFO is taken only if a pop frees the slot.
module tileXY_eject_fifo import tilexy_pkg::*; #(
  parameter  int DEPTH = 8,
  parameter  int W     = WRREQ_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [AW:0]  o_count,
  output logic         o_full,
  output logic         o_empty
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;

  assign o_full  = (r_cnt == DEPTH[AW:0]);
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/tilexy_cl_rx.sv
// Ring receiver: eject local flits into per-direction FIFOs, forward the rest one hop,
// round-robin the two FIFOs onto a single cache port.
module tilexy_cl_rx import tilexy_pkg::*; #(
  parameter logic [4:0] TILE_X = 5'd0,
  parameter logic [4:0] TILE_Y = 5'd0,
  parameter int         DEPTH  = 8,
  parameter int         AF_LVL = 6
) (
  input logic           clk,
  input logic           rst,
  tilexy_cl_rx_if.slave bus
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] AF_C = AF_LVL[AW:0];

  logic [1:0]   w_hit, w_fwd, w_drop, w_pop, w_ne;
  wrreq_t       w_head [2];
  logic [AW:0]  w_cnt  [2];
  logic         w_full [2];
  logic         w_empty[2];
  logic         w_valid, w_gnt;
  wrreq_t       w_sel;
  wire          w_unused_extra = ^{bus.link_in[0][EXTRA], bus.link_in[1][EXTRA]};

  wrreq_t [1:0] r_stg;
  logic   [1:0] r_lfo, r_ovf;
  logic         r_rr, r_hold_v, r_hold_dir;

  always_comb begin
    w_hit  = '0;
    w_fwd  = '0;
    w_drop = '0;
    for (int d = 0; d < 2; d++) begin
      w_hit[d]  = bus.link_in[d][SND] && (bus.link_in[d][TX_MSB:TX_LSB] == TILE_X)
                                      && (bus.link_in[d][TY_MSB:TY_LSB] == TILE_Y);
      w_fwd[d]  = bus.link_in[d][SND] && !w_hit[d];
      w_drop[d] = w_hit[d] && w_full[d] && !w_pop[d];
    end
  end

  for (genvar d = 0; d < 2; d++) begin : g_fifo
    tileXY_eject_fifo #(.DEPTH(DEPTH), .W(WRREQ_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_hit[d]),
      .i_data  (bus.link_in[d][WRREQ_W-1:0]),
      .i_pop   (w_pop[d]),
      .o_head  (w_head[d]),
      .o_count (w_cnt[d]),
      .o_full  (w_full[d]),
      .o_empty (w_empty[d])
    );
  end

  // Grant is frozen while a presented line waits for ready, so out_* never switches mid-offer.
  always_comb begin
    w_ne    = {~w_empty[1], ~w_empty[0]};
    w_valid = |w_ne;
    w_gnt   = r_hold_v ? r_hold_dir : (&w_ne ? r_rr : w_ne[1]);
    w_pop   = '0;
    w_pop[w_gnt] = w_valid && bus.out_ready;
    w_sel   = w_head[w_gnt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stg      <= '0;
      r_lfo      <= '0;
      r_ovf      <= '0;
      r_rr       <= 1'b0;
      r_hold_v   <= 1'b0;
      r_hold_dir <= 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        // A loaded stage always carries snd=1, so that bit doubles as the stage-full flag.
        if (!r_stg[d][SND] || !bus.fwd_full_in[d])
          r_stg[d] <= w_fwd[d] ? bus.link_in[d][WRREQ_W-1:0] : '0;
        if (w_drop[d] || (w_fwd[d] && r_stg[d][SND] && bus.fwd_full_in[d]))
          r_ovf[d] <= 1'b1;
        r_lfo[d] <= (w_cnt[d] >= AF_C) || (r_stg[d][SND] && bus.fwd_full_in[d]);
      end
      r_hold_v   <= w_valid && !bus.out_ready;
      r_hold_dir <= w_gnt;
      if (w_valid && bus.out_ready && (&w_ne)) r_rr <= ~w_gnt;
    end
  end

  assign bus.fwd_out       = r_stg;
  assign bus.link_full_out = r_lfo;
  assign bus.ovf_err       = r_ovf;
  assign bus.out_valid     = w_valid;
  assign bus.out_dir       = w_gnt;
  assign bus.out_data      = w_sel[DATA_MSB:DATA_LSB];
  assign bus.out_addr      = w_sel[ADDR_MSB:ADDR_LSB];
  assign bus.out_size      = cl_size(w_sel);
  assign bus.out_expun     = w_sel[EXPUN];
endmodule
